// File: rtl/aud_recorder_pkg.sv
// Shared definitions for the audio capture path.
// Holds the recorder state enum, the sample and SRAM address widths, the I2S
// left-slot length, and the default last writable SRAM address.
package aud_recorder_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 20;
    localparam int SLOT_LEN = 16;
    localparam int BITCNT_W = $clog2(SLOT_LEN);

    localparam logic [ADDR_W-1:0] MAX_ADDR_DEF = 20'hFFFFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT_L = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_PAUSE  = 2'd3
    } rec_state_e;

endpackage

// File: rtl/aud_recorder_if.sv
// SRAM write-port bundle between the recorder (master) and Top (slave).
// Ports/signals:
//   wr_en   master->slave  write request, held until acknowledged
//   address master->slave  SRAM word address of the pending write
//   data    master->slave  sample to be written
//   wr_ack  slave->master  one-cycle pulse: Top accepted the current write
interface aud_recorder_if;
    import aud_recorder_pkg::*;

    logic              wr_en;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data;
    logic              wr_ack;

    modport master (output wr_en, output address, output data, input wr_ack);
    modport slave  (input wr_en, input address, input data, output wr_ack);

endinterface

// File: rtl/aud_recorder_i2s_rx_shift.sv
// I2S left-slot receiver: detects the LRC falling edge, skips the one-bit
// delay slot and shifts in a 16-bit word MSB first.
// Ports:
//   i_clk, i_rst   BCLK and synchronous active-high reset
//   i_en           high while the recorder is in WAIT_L or SHIFT; low clears all state
//   i_shift        high while the recorder is in SHIFT
//   i_lrc, i_dat   codec ADCLRCK and ADCDAT
//   o_lrc_fall     this cycle is the delay slot after LRC fell (only while waiting)
//   o_word         assembled word, valid together with o_word_valid
//   o_word_valid   the 16th bit is being sampled this cycle
module aud_recorder_i2s_rx_shift
    import aud_recorder_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_shift,
    input  logic              i_lrc,
    input  logic              i_dat,
    output logic              o_lrc_fall,
    output logic [DATA_W-1:0] o_word,
    output logic              o_word_valid
);

    logic                r_lrcD;
    logic [BITCNT_W-1:0] r_bitCnt;
    logic [DATA_W-2:0]   r_shift;
    logic                w_lastBit;

    // The final bit is never stored: the word is presented combinationally
    // with the live data bit so the top can register it on the same edge.
    assign w_lastBit    = (r_bitCnt == BITCNT_W'(SLOT_LEN - 1));
    assign o_lrc_fall   = i_en && !i_shift && r_lrcD && !i_lrc;
    assign o_word_valid = i_en && i_shift && w_lastBit;
    assign o_word       = {r_shift, i_dat};

    // LRC history is tracked through both waiting and shifting so that a low
    // LRC on return to waiting is never mistaken for a fresh falling edge.
    // Disabling (pause/stop/idle) wipes everything, which discards any
    // partial word and forces a clean edge to be seen after re-enabling.
    always_ff @(posedge i_clk) begin
        if (i_rst || !i_en) begin
            r_lrcD   <= 1'b0;
            r_bitCnt <= '0;
            r_shift  <= '0;
        end else begin
            r_lrcD <= i_lrc;
            if (i_shift) begin
                r_shift  <= {r_shift[DATA_W-3:0], i_dat};
                r_bitCnt <= w_lastBit ? '0 : r_bitCnt + BITCNT_W'(1);
            end else begin
                r_bitCnt <= '0;
            end
        end
    end

endmodule

// File: rtl/aud_recorder.sv
// Capture path: records left-channel I2S samples from the codec ADC into SRAM
// at consecutive addresses, one acknowledged write per frame.
// Ports:
//   i_clk, i_rst          BCLK and synchronous active-high reset
//   i_start/i_pause/i_stop level controls (priority stop > pause > start)
//   i_lrc, i_adc_dat      codec serial input
//   io_sram               SRAM write port (master side)
//   o_sample_cnt          acknowledged writes since the last start from IDLE
//   o_full                sticky: last writable address was written
//   o_overrun             sticky: a completed word was dropped
//   o_busy                recorder is not IDLE
module aud_recorder
    import aud_recorder_pkg::*;
#(
    parameter logic [ADDR_W-1:0] MAX_ADDR = MAX_ADDR_DEF
)(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic              i_lrc,
    input  logic              i_adc_dat,
    aud_recorder_if.master    io_sram,
    output logic [ADDR_W-1:0] o_sample_cnt,
    output logic              o_full,
    output logic              o_overrun,
    output logic              o_busy
);

    rec_state_e        r_state;
    rec_state_e        w_nextState;
    logic              r_pending;
    logic [ADDR_W-1:0] r_address;
    logic [DATA_W-1:0] r_data;
    logic [ADDR_W-1:0] r_sampleCnt;
    logic              r_full;
    logic              r_overrun;

    logic              w_lrcFall;
    logic [DATA_W-1:0] w_word;
    logic              w_wordValid;
    logic              w_ack;
    logic              w_ackLast;
    logic              w_load;
    logic              w_drop;
    logic              w_startFromIdle;

    aud_recorder_i2s_rx_shift u_rx (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_en         ((r_state == ST_WAIT_L) || (r_state == ST_SHIFT)),
        .i_shift      (r_state == ST_SHIFT),
        .i_lrc        (i_lrc),
        .i_dat        (i_adc_dat),
        .o_lrc_fall   (w_lrcFall),
        .o_word       (w_word),
        .o_word_valid (w_wordValid)
    );

    // Next-state and write-path decisions. A word finishing in the same cycle
    // as pause/stop is treated as part of the abandoned slot. Acking the last
    // address ends recording, so a word completing then is silently dropped.
    always_comb begin
        w_nextState     = r_state;
        w_ack           = io_sram.wr_ack && r_pending;
        w_ackLast       = w_ack && (r_address == MAX_ADDR);
        w_load          = w_wordValid && !i_stop && !i_pause && !r_pending;
        w_drop          = w_wordValid && !i_stop && !i_pause && r_pending && !w_ackLast;
        w_startFromIdle = (r_state == ST_IDLE) && i_start && !i_stop && !i_pause;

        case (r_state)
            ST_IDLE: begin
                if (w_startFromIdle) w_nextState = ST_WAIT_L;
            end
            ST_WAIT_L: begin
                if (i_stop)         w_nextState = ST_IDLE;
                else if (i_pause)   w_nextState = ST_PAUSE;
                else if (w_lrcFall) w_nextState = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (i_stop)           w_nextState = ST_IDLE;
                else if (i_pause)     w_nextState = ST_PAUSE;
                else if (w_wordValid) w_nextState = ST_WAIT_L;
            end
            ST_PAUSE: begin
                if (i_stop)                  w_nextState = ST_IDLE;
                else if (!i_pause && i_start) w_nextState = ST_WAIT_L;
            end
            default: w_nextState = ST_IDLE;
        endcase

        if (w_ackLast) w_nextState = ST_IDLE;
    end

    // State, pending write and bookkeeping. Stop abandons an unacked write
    // without advancing address or count, but an ack in that same cycle still
    // counts. Sticky flags are only cleared by a fresh start from IDLE.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_pending   <= 1'b0;
            r_address   <= '0;
            r_data      <= '0;
            r_sampleCnt <= '0;
            r_full      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state <= w_nextState;

            if (w_ack || i_stop) begin
                r_pending <= 1'b0;
            end else if (w_load) begin
                r_pending <= 1'b1;
                r_data    <= w_word;
            end

            if (w_startFromIdle) begin
                r_address   <= '0;
                r_sampleCnt <= '0;
                r_full      <= 1'b0;
                r_overrun   <= 1'b0;
            end else begin
                if (w_ack) begin
                    r_sampleCnt <= r_sampleCnt + ADDR_W'(1);
                    if (r_address == MAX_ADDR) r_full <= 1'b1;
                    else                       r_address <= r_address + ADDR_W'(1);
                end
                if (w_drop) r_overrun <= 1'b1;
            end
        end
    end

    assign io_sram.wr_en   = r_pending;
    assign io_sram.address = r_address;
    assign io_sram.data    = r_data;
    assign o_sample_cnt    = r_sampleCnt;
    assign o_full          = r_full;
    assign o_overrun       = r_overrun;
    assign o_busy          = (r_state != ST_IDLE);

endmodule

// File: tb/tb_aud_recorder.sv
// Testbench for aud_recorder: drives whole I2S frames (32 BCLK, left slot
// LRC low for 16 cycles, MSB one cycle after the LRC fall), acts as the SRAM
// owner that acknowledges writes, and scores every accepted write against a
// frame-level model of what a recorder should store.
module tb_aud_recorder;
    import aud_recorder_pkg::*;

    localparam logic [ADDR_W-1:0] TB_MAX_ADDR = 20'd11;

    typedef enum {EV_NONE, EV_START, EV_PAUSE, EV_STOP, EV_STOPSTART, EV_RESET} ev_e;
    typedef enum {M_IDLE, M_REC, M_PAUSED} mstate_e;

    logic              clk;
    logic              rst;
    logic              start;
    logic              pause;
    logic              stop;
    logic              lrc;
    logic              adcDat;
    logic [ADDR_W-1:0] sampleCnt;
    logic              full;
    logic              overrun;
    logic              busy;

    aud_recorder_if sram ();

    aud_recorder #(.MAX_ADDR(TB_MAX_ADDR)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_pause      (pause),
        .i_stop       (stop),
        .i_lrc        (lrc),
        .i_adc_dat    (adcDat),
        .io_sram      (sram),
        .o_sample_cnt (sampleCnt),
        .o_full       (full),
        .o_overrun    (overrun),
        .o_busy       (busy)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: what has been recorded, at frame granularity.
    mstate_e           mState    = M_IDLE;
    logic [ADDR_W-1:0] mAddr     = '0;
    logic [ADDR_W-1:0] mCnt      = '0;
    logic              mFull     = 1'b0;
    logic              mOverrun  = 1'b0;
    logic              mPendValid = 1'b0;
    logic [DATA_W-1:0] mPendWord = '0;
    logic [ADDR_W+DATA_W-1:0] expQ[$];

    bit ackEnable = 1'b1;
    int ackDelay  = 2;
    int ackWait   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic checkZeros(input string tag);
        checkOutput({tag, " wr_en"},   32'(sram.wr_en),   32'd0);
        checkOutput({tag, " address"}, 32'(sram.address), 32'd0);
        checkOutput({tag, " data"},    32'(sram.data),    32'd0);
        checkOutput({tag, " cnt"},     32'(sampleCnt),    32'd0);
        checkOutput({tag, " full"},    32'(full),         32'd0);
        checkOutput({tag, " overrun"}, 32'(overrun),      32'd0);
        checkOutput({tag, " busy"},    32'(busy),         32'd0);
    endtask

    // A pending sample is written to the next address; writing the last
    // address fills the memory and ends the recording.
    task automatic modelCommit();
        expQ.push_back({mAddr, mPendWord});
        mPendValid = 1'b0;
        mCnt = mCnt + 1'b1;
        if (mAddr == TB_MAX_ADDR) begin
            mFull  = 1'b1;
            mState = M_IDLE;
        end else begin
            mAddr = mAddr + 1'b1;
        end
    endtask

    task automatic clearModel();
        mAddr = '0; mCnt = '0; mFull = 1'b0; mOverrun = 1'b0;
    endtask

    // One frame: control events land at cycle 8 (mid left slot) or cycle 24
    // (right slot); holdAck withholds Top's acknowledge for the whole frame.
    task automatic applyStimulus(input logic [DATA_W-1:0] word, input ev_e ev, input bit holdAck);
        for (int t = 0; t < 32; t++) begin
            @(negedge clk);
            rst = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0;
            lrc    = (t >= 16);
            adcDat = (t >= 1 && t <= 16) ? word[16 - t] : 1'($urandom);
            if (t == 0) begin
                ackEnable = !holdAck;
                if (!holdAck && mPendValid) modelCommit();
            end
            if (t == 8) begin
                case (ev)
                    EV_PAUSE: begin
                        pause = 1'b1;
                        if (mState == M_REC) mState = M_PAUSED;
                    end
                    EV_STOP, EV_STOPSTART: begin
                        stop  = 1'b1;
                        start = (ev == EV_STOPSTART);
                        if (mState != M_IDLE) begin
                            mState = M_IDLE;
                            mPendValid = 1'b0;
                        end
                    end
                    EV_RESET: begin
                        rst = 1'b1;
                        mState = M_IDLE;
                        mPendValid = 1'b0;
                        clearModel();
                    end
                    default: ;
                endcase
            end
            if (t == 9 && ev == EV_RESET) checkZeros("reset mid-frame");
            if (t == 16 && mState == M_REC) begin
                if (mPendValid) begin
                    mOverrun = 1'b1;
                end else begin
                    mPendValid = 1'b1;
                    mPendWord  = word;
                    if (!holdAck) modelCommit();
                end
            end
            if (t == 24 && ev == EV_START) begin
                start = 1'b1;
                if (mState == M_IDLE) begin
                    mState = M_REC;
                    clearModel();
                end else if (mState == M_PAUSED) begin
                    mState = M_REC;
                end
            end
            if (t == 31) begin
                checkOutput("sample_cnt", 32'(sampleCnt), 32'(mCnt));
                checkOutput("full",       32'(full),      32'(mFull));
                checkOutput("overrun",    32'(overrun),   32'(mOverrun));
                checkOutput("busy",       32'(busy),      32'(mState != M_IDLE));
                checkOutput("wr_en",      32'(sram.wr_en), 32'(mPendValid));
                if (mPendValid) begin
                    checkOutput("held address", 32'(sram.address), 32'(mAddr));
                    checkOutput("held data",    32'(sram.data),    32'(mPendWord));
                end
            end
        end
    endtask

    // Top's side of the write port: acknowledge a request ackDelay cycles
    // after it appears, and occasionally pulse a stray ack while idle.
    initial begin
        sram.wr_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (sram.wr_ack) begin
                sram.wr_ack = 1'b0;
                ackWait = 0;
            end else if (sram.wr_en) begin
                if (ackEnable && ackWait >= ackDelay) sram.wr_ack = 1'b1;
                else if (ackEnable) ackWait++;
                else ackWait = 0;
            end else begin
                ackWait = 0;
                sram.wr_ack = ($urandom_range(0, 7) == 0);
            end
        end
    end

    // Scoreboard monitor: every write Top accepts must match the next
    // expected address/sample.
    initial begin
        logic [ADDR_W+DATA_W-1:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (sram.wr_en && sram.wr_ack) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected write: got addr %0h data %0h expected none", sram.address, sram.data);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("write address", 32'(sram.address), 32'(e[ADDR_W+DATA_W-1:DATA_W]));
                    checkOutput("write data",    32'(sram.data),    32'(e[DATA_W-1:0]));
                end
            end
        end
    end

    initial begin
        #2000000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        ev_e ev;
        rst = 1'b1; start = 1'b0; pause = 1'b0; stop = 1'b0; lrc = 1'b1; adcDat = 1'b0;
        repeat (3) @(negedge clk);
        checkZeros("reset");
        rst = 1'b0;

        $display("[TB] basic recording of four frames");
        ackDelay = 2;
        applyStimulus(16'($urandom), EV_START, 1'b0);
        applyStimulus(16'h8001, EV_NONE, 1'b0);
        applyStimulus(16'h1234, EV_NONE, 1'b0);
        applyStimulus(16'h7FFF, EV_NONE, 1'b0);
        applyStimulus(16'h0000, EV_NONE, 1'b0);

        $display("[TB] withheld acknowledge causes overrun");
        applyStimulus(16'hA5A5, EV_NONE, 1'b1);
        applyStimulus(16'h5A5A, EV_NONE, 1'b1);
        applyStimulus(16'hC3C3, EV_NONE, 1'b0);

        $display("[TB] pause mid-slot and resume");
        applyStimulus(16'hDEAD, EV_PAUSE, 1'b0);
        applyStimulus(16'hBEEF, EV_NONE, 1'b0);
        applyStimulus(16'hFACE, EV_START, 1'b0);
        applyStimulus(16'h0F0F, EV_NONE, 1'b0);

        $display("[TB] fill memory to the last address");
        for (int i = 0; i < 6; i++) applyStimulus(16'($urandom), EV_NONE, 1'b0);

        $display("[TB] stop with pending write, stop+start in slot");
        applyStimulus(16'($urandom), EV_START, 1'b0);
        applyStimulus(16'h1111, EV_NONE, 1'b1);
        applyStimulus(16'h2222, EV_STOP, 1'b1);
        applyStimulus(16'($urandom), EV_START, 1'b0);
        applyStimulus(16'h3333, EV_NONE, 1'b0);
        applyStimulus(16'h4444, EV_STOPSTART, 1'b0);

        $display("[TB] reset during slot with pending write");
        applyStimulus(16'($urandom), EV_START, 1'b0);
        applyStimulus(16'h5555, EV_NONE, 1'b1);
        applyStimulus(16'h6666, EV_RESET, 1'b1);

        $display("[TB] randomized frames");
        for (int f = 0; f < 250; f++) begin
            int r;
            r = $urandom_range(0, 19);
            ev = EV_NONE;
            if (r <= 2)                          ev = EV_START;
            else if (r == 3)                     ev = EV_PAUSE;
            else if (r == 4)                     ev = EV_STOP;
            else if (r == 5 && mState != M_IDLE) ev = EV_STOPSTART;
            else if (r == 6 && $urandom_range(0, 3) == 0) ev = EV_RESET;
            ackDelay = $urandom_range(0, 4);
            applyStimulus(16'($urandom), ev, ($urandom_range(0, 4) == 0));
        end

        ackEnable = 1'b1;
        applyStimulus(16'($urandom), EV_STOP, 1'b0);
        repeat (4) @(negedge clk);
        checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
